stack_mem_controller: RTL and testbench

- Memory-stage sequencer for the 16-bit data/stack memory; sits between pipeline MEM stage and the memory array.
- Owns the stack pointer; translates LOAD/STORE/PUSH/POP/CALL/RET into per-cycle memory write/read strobes.
- Splits 32-bit PC pushes/pops into two 16-bit accesses, stalling the pipeline for one extra cycle.

---
 rtl/stack_mem_controller.sv | 207 ++++++++++++++++++++
 tb/tb_stack_mem_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_controller.sv
// Memory-stage sequencer: owns the stack pointer and turns LOAD/STORE/PUSH/POP/CALL/RET
// into per-cycle strobes on a 16-bit memory, splitting 32-bit PC transfers into two accesses.
module stack_mem_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_BITS   = 11,
   parameter int STACK_BASE = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   input  logic [2:0]            op_code,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic [31:0]           pc_in,
   output logic                  ready,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  load_valid,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  pc_valid,
   output logic [31:0]           pc_out,
   output logic [MEM_BITS-1:0]   sp,
   output logic                  addr_err,
   output logic                  stack_ovf,
   output logic                  stack_unf
);
   localparam logic [MEM_BITS-1:0] SP_TOP     = '1;
   localparam logic [MEM_BITS-1:0] SP_BASE    = MEM_BITS'(STACK_BASE);
   localparam logic [MEM_BITS-1:0] SP_RET_MAX = SP_TOP - MEM_BITS'(2);
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_PUSH  = 3'd3;
   localparam logic [2:0] OP_POP   = 3'd4;
   localparam logic [2:0] OP_CALL  = 3'd5;
   localparam logic [2:0] OP_RET   = 3'd6;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALL2 = 2'd1, S_RET2 = 2'd2} state_t;

   state_t                state_q;
   logic [MEM_BITS-1:0]   sp_q;
   logic [15:0]           half_q;
   logic                  load_valid_q;
   logic [DATA_WIDTH-1:0] load_data_q;
   logic                  pc_valid_q;
   logic [31:0]           pc_out_q;
   logic                  addr_err_q;
   logic                  ovf_q;
   logic                  unf_q;

   logic                  addr_oob;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  call_ok;
   logic                  ret_ok;
   logic [MEM_BITS-1:0]   sp_m1;
   logic [MEM_BITS-1:0]   sp_p1;
   logic [MEM_BITS-1:0]   sp_p2;

   assign addr_oob = |addr_in[ADDR_WIDTH-1:MEM_BITS];
   assign sp_m1    = sp_q - MEM_BITS'(1);
   assign sp_p1    = sp_q + MEM_BITS'(1);
   assign sp_p2    = sp_q + MEM_BITS'(2);
   assign push_ok  = sp_q >= SP_BASE;
   assign pop_ok   = sp_q != SP_TOP;
   assign call_ok  = sp_q > SP_BASE;
   assign ret_ok   = sp_q <= SP_RET_MAX;

   // Strobes are decoded straight from state and the live request; ready drops only
   // while a legal CALL/RET is in its first half so the requester holds it one more cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ready     = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               case (op_code)
                  OP_LOAD: if (!addr_oob) begin
                     mem_re   = 1'b1;
                     mem_addr = addr_in;
                  end
                  OP_STORE: if (!addr_oob) begin
                     mem_we    = 1'b1;
                     mem_addr  = addr_in;
                     mem_wdata = wdata_in;
                  end
                  OP_PUSH: if (push_ok) begin
                     mem_we    = 1'b1;
                     mem_addr  = ADDR_WIDTH'(sp_q);
                     mem_wdata = wdata_in;
                  end
                  OP_POP: if (pop_ok) begin
                     mem_re   = 1'b1;
                     mem_addr = ADDR_WIDTH'(sp_p1);
                  end
                  OP_CALL: if (call_ok) begin
                     mem_we    = 1'b1;
                     mem_addr  = ADDR_WIDTH'(sp_q);
                     mem_wdata = DATA_WIDTH'(pc_in[31:16]);
                     ready     = 1'b0;
                  end
                  OP_RET: if (ret_ok) begin
                     mem_re   = 1'b1;
                     mem_addr = ADDR_WIDTH'(sp_p1);
                     ready    = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         S_CALL2: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_WIDTH'(sp_m1);
            mem_wdata = DATA_WIDTH'(half_q);
         end
         S_RET2: begin
            mem_re   = 1'b1;
            mem_addr = ADDR_WIDTH'(sp_p2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sp_q         <= SP_TOP;
         half_q       <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         pc_valid_q   <= 1'b0;
         pc_out_q     <= '0;
         addr_err_q   <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         pc_valid_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (op_valid) begin
                  case (op_code)
                     OP_LOAD: begin
                        if (addr_oob) addr_err_q <= 1'b1;
                        else begin
                           load_valid_q <= 1'b1;
                           load_data_q  <= mem_rdata;
                        end
                     end
                     OP_STORE: if (addr_oob) addr_err_q <= 1'b1;
                     OP_PUSH: begin
                        if (push_ok) sp_q <= sp_m1;
                        else ovf_q <= 1'b1;
                     end
                     OP_POP: begin
                        if (pop_ok) begin
                           sp_q         <= sp_p1;
                           load_valid_q <= 1'b1;
                           load_data_q  <= mem_rdata;
                        end else unf_q <= 1'b1;
                     end
                     OP_CALL: begin
                        if (call_ok) begin
                           half_q  <= pc_in[15:0];
                           state_q <= S_CALL2;
                        end else ovf_q <= 1'b1;
                     end
                     OP_RET: begin
                        if (ret_ok) begin
                           half_q  <= mem_rdata[15:0];
                           state_q <= S_RET2;
                        end else unf_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALL2: begin
               sp_q    <= sp_q - MEM_BITS'(2);
               state_q <= S_IDLE;
            end
            S_RET2: begin
               pc_out_q   <= {mem_rdata[15:0], half_q};
               pc_valid_q <= 1'b1;
               sp_q       <= sp_p2;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign pc_valid   = pc_valid_q;
   assign pc_out     = pc_out_q;
   assign sp         = sp_q;
   assign addr_err   = addr_err_q;
   assign stack_ovf  = ovf_q;
   assign stack_unf  = unf_q;
endmodule

// File: tb/tb_stack_mem_controller.sv
// Directed bench for stack_mem_controller: a word-array memory, a bench-side stack image,
// and queues of expected load_data / pc_out values consumed when the pulses arrive.
module tb_stack_mem_controller;
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_PUSH  = 3'd3;
   localparam logic [2:0] OP_POP   = 3'd4;
   localparam logic [2:0] OP_CALL  = 3'd5;
   localparam logic [2:0] OP_RET   = 3'd6;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] addr_in;
   logic [15:0] wdata_in;
   logic [31:0] pc_in;
   logic        ready;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        load_valid;
   logic [15:0] load_data;
   logic        pc_valid;
   logic [31:0] pc_out;
   logic [10:0] sp;
   logic        addr_err;
   logic        stack_ovf;
   logic        stack_unf;

   logic [15:0] mem [0:2047];
   logic [15:0] stk [0:2047];
   logic [15:0] exp_q[$];
   logic [31:0] pc_q[$];
   int          total = 0;
   int          bad = 0;
   int          exp_sp;
   logic [15:0] saved;

   stack_mem_controller dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .addr_in(addr_in),
      .wdata_in(wdata_in), .pc_in(pc_in), .ready(ready), .mem_we(mem_we), .mem_re(mem_re),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .load_valid(load_valid), .load_data(load_data), .pc_valid(pc_valid), .pc_out(pc_out),
      .sp(sp), .addr_err(addr_err), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   // Clock and memory array
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'd2048) mem[mem_addr[10:0]] <= mem_wdata;
   end
   assign mem_rdata = mem_re ? mem[mem_addr[10:0]] : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [15:0] d,
                        input logic [31:0] pc);
      op_valid = 1'b1;
      op_code  = op;
      addr_in  = a;
      wdata_in = d;
      pc_in    = pc;
      #1;
   endtask

   task automatic idle();
      op_valid = 1'b0;
      op_code  = OP_NOP;
      addr_in  = '0;
      wdata_in = '0;
      pc_in    = '0;
      #1;
   endtask

   // Advance one cycle; the scoreboard consumes any result pulse seen on the way.
   task automatic nxt();
      @(negedge clk);
      if (load_valid) begin
         chk("load_valid_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("load_data", 32'(load_data), 32'(exp_q.pop_front()));
      end
      if (pc_valid) begin
         chk("pc_valid_pending", 32'(pc_q.size() != 0), 32'd1);
         if (pc_q.size() != 0) chk("pc_out", pc_out, pc_q.pop_front());
      end
   endtask

   task automatic do_push(input logic [15:0] d);
      apply(OP_PUSH, 32'd0, d, 32'd0);
      if (exp_sp >= 1024) begin
         chk("push_we", 32'(mem_we), 32'd1);
         chk("push_addr", mem_addr, exp_sp);
         chk("push_wdata", 32'(mem_wdata), 32'(d));
         stk[exp_sp] = d;
         exp_sp--;
      end else begin
         chk("push_ovf_no_we", 32'(mem_we), 32'd0);
         chk("push_ovf_ready", 32'(ready), 32'd1);
      end
      nxt();
      idle();
      chk("push_sp", 32'(sp), exp_sp);
   endtask

   task automatic do_pop();
      apply(OP_POP, 32'd0, 16'd0, 32'd0);
      if (exp_sp < 2047) begin
         chk("pop_re", 32'(mem_re), 32'd1);
         chk("pop_addr", mem_addr, exp_sp + 1);
         exp_q.push_back(stk[exp_sp + 1]);
         exp_sp++;
      end else begin
         chk("pop_unf_no_re", 32'(mem_re), 32'd0);
         chk("pop_unf_ready", 32'(ready), 32'd1);
      end
      nxt();
      idle();
      chk("pop_sp", 32'(sp), exp_sp);
   endtask

   task automatic do_call(input logic [31:0] pc);
      apply(OP_CALL, 32'd0, 16'd0, pc);
      chk("call1_ready", 32'(ready), 32'd0);
      chk("call1_we", 32'(mem_we), 32'd1);
      chk("call1_addr", mem_addr, exp_sp);
      chk("call1_wdata", 32'(mem_wdata), 32'(pc[31:16]));
      nxt();
      chk("call2_ready", 32'(ready), 32'd1);
      chk("call2_we", 32'(mem_we), 32'd1);
      chk("call2_addr", mem_addr, exp_sp - 1);
      chk("call2_wdata", 32'(mem_wdata), 32'(pc[15:0]));
      stk[exp_sp]     = pc[31:16];
      stk[exp_sp - 1] = pc[15:0];
      exp_sp -= 2;
      nxt();
      idle();
      chk("call_sp", 32'(sp), exp_sp);
   endtask

   task automatic do_ret();
      apply(OP_RET, 32'd0, 16'd0, 32'd0);
      chk("ret1_ready", 32'(ready), 32'd0);
      chk("ret1_re", 32'(mem_re), 32'd1);
      chk("ret1_addr", mem_addr, exp_sp + 1);
      pc_q.push_back({stk[exp_sp + 2], stk[exp_sp + 1]});
      nxt();
      chk("ret2_ready", 32'(ready), 32'd1);
      chk("ret2_re", 32'(mem_re), 32'd1);
      chk("ret2_addr", mem_addr, exp_sp + 2);
      exp_sp += 2;
      nxt();
      idle();
      chk("ret_sp", 32'(sp), exp_sp);
      nxt();
      chk("pc_valid_pulse", 32'(pc_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      exp_sp = 2047;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_sp", 32'(sp), 32'd2047);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_re", 32'(mem_re), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_load_valid", 32'(load_valid), 32'd0);
      chk("rst_load_data", 32'(load_data), 32'd0);
      chk("rst_pc_valid", 32'(pc_valid), 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_flags", {29'd0, addr_err, stack_ovf, stack_unf}, 32'd0);

      // Push/pop round trip and one-cycle load pulse
      do_push(16'hBEEF);
      do_pop();
      nxt();
      chk("load_valid_pulse", 32'(load_valid), 32'd0);

      // CALL/RET through the top of the stack
      do_call(32'h0001_2345);
      chk("call_mem_hi", 32'(mem[2047]), 32'h0001);
      chk("call_mem_lo", 32'(mem[2046]), 32'h2345);
      do_ret();

      // Underflow: RET with one word on the stack, POP on an empty stack
      do_push(16'h1111);
      apply(OP_RET, 32'd0, 16'd0, 32'd0);
      chk("ret_unf_re", 32'(mem_re), 32'd0);
      chk("ret_unf_we", 32'(mem_we), 32'd0);
      chk("ret_unf_ready", 32'(ready), 32'd1);
      nxt();
      idle();
      chk("ret_unf_sp", 32'(sp), 32'd2046);
      chk("ret_unf_flag", 32'(stack_unf), 32'd1);
      chk("ret_unf_no_ovf", 32'(stack_ovf), 32'd0);
      do_pop();
      do_pop();
      chk("pop_unf_flag", 32'(stack_unf), 32'd1);

      // Fill down to the stack base, then overflow
      while (exp_sp > 1024) do_push(16'($urandom_range(0, 65535)));
      chk("fill_ovf_clear", 32'(stack_ovf), 32'd0);
      do_push(16'h0BAD);
      chk("base_push_ovf_clear", 32'(stack_ovf), 32'd0);
      do_push(16'h0DEF);
      chk("push_ovf_flag", 32'(stack_ovf), 32'd1);
      do_pop();
      apply(OP_CALL, 32'd0, 16'd0, 32'h1234_5678);
      chk("call_ovf_we", 32'(mem_we), 32'd0);
      chk("call_ovf_ready", 32'(ready), 32'd1);
      nxt();
      idle();
      chk("call_ovf_sp", 32'(sp), 32'd1024);
      do_pop();
      do_call(32'hCAFE_0042);
      do_ret();

      // Plain LOAD/STORE and the address range check
      apply(OP_STORE, 32'd5, 16'h00A5, 32'd0);
      chk("store_we", 32'(mem_we), 32'd1);
      chk("store_addr", mem_addr, 32'd5);
      chk("store_wdata", 32'(mem_wdata), 32'h00A5);
      nxt();
      idle();
      chk("store_addr_err_clear", 32'(addr_err), 32'd0);
      apply(OP_LOAD, 32'd5, 16'd0, 32'd0);
      chk("load_re", 32'(mem_re), 32'd1);
      chk("load_addr", mem_addr, 32'd5);
      exp_q.push_back(16'h00A5);
      nxt();
      idle();
      apply(OP_LOAD, 32'h0000_0800, 16'd0, 32'd0);
      chk("load_oob_re", 32'(mem_re), 32'd0);
      nxt();
      idle();
      chk("load_oob_err", 32'(addr_err), 32'd1);
      chk("load_oob_no_valid", 32'(load_valid), 32'd0);
      apply(OP_STORE, 32'hFFFF_0000, 16'h5A5A, 32'd0);
      chk("store_oob_we", 32'(mem_we), 32'd0);
      nxt();
      idle();

      // Reset arriving while the second CALL write is pending
      saved = mem[exp_sp - 1];
      apply(OP_CALL, 32'd0, 16'd0, 32'h7777_8888);
      nxt();
      chk("abort_in_call2_we", 32'(mem_we), 32'd1);
      chk("abort_in_call2_addr", mem_addr, exp_sp - 1);
      idle();
      rst = 1'b1;
      #1;
      chk("abort_we", 32'(mem_we), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_sp", 32'(sp), 32'd2047);
      chk("abort_flags", {29'd0, addr_err, stack_ovf, stack_unf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_sp = 2047;
      nxt();
      chk("abort_no_second_write", 32'(mem[1024]), 32'(saved));
      chk("abort_idle_we", 32'(mem_we), 32'd0);
      chk("abort_idle_sp", 32'(sp), 32'd2047);

      repeat (3) nxt();
      chk("load_q_drained", exp_q.size(), 32'd0);
      chk("pc_q_drained", pc_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
